parcial_junto: RTL and testbench

- Sequential iterative Fibonacci calculator: on `start`, computes F(n) for a 16-bit index n and presents a 32-bit result on `F`.
- Standalone compute block with a single clock domain.
- Controlled by a simple start/busy/done handshake; `start` may be held high for back-to-back recomputation.

---
 rtl/parcial_junto.sv | 161 ++++++++++++++++
 tb/tb_parcial_junto.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/parcial_junto.sv
// -----------------------------------------------------------------------------
// parcial_junto
// Iterative Fibonacci calculator. A start request sampled in IDLE latches the
// index n; the CALC state runs one addition per cycle until the down-counter
// reaches zero, then the result is registered on F and DONE pulses for a
// single cycle. Holding start high recomputes back-to-back (period n+3).
//
// Optional build macro: FIB_OVF_EN
//   When defined, adds output `ovf`. The flag reports whether the returned
//   value F(n) itself wrapped, i.e. whether any addition that contributed to it
//   carried out of F_W bits. It is registered together with F at completion.
//   When undefined, there is no `ovf` port and results wrap silently.
// -----------------------------------------------------------------------------
module parcial_junto #(
    parameter int N_W = 16,
    parameter int F_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N_W-1:0] n,
    output logic [F_W-1:0] F,
    output logic           busy,
    output logic           done
`ifdef FIB_OVF_EN
    ,
    output logic           ovf
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;

    // a holds F(k), b holds F(k+1) after k iterations.
    logic [F_W-1:0] a_q, a_d;
    logic [F_W-1:0] b_q, b_d;
    logic [N_W-1:0] cnt_q, cnt_d;
    logic [F_W-1:0] f_q, f_d;

    // One extra bit captures the carry out of the modulo-2^F_W addition.
    logic [F_W:0]   sum_w;

    assign sum_w = {1'b0, a_q} + {1'b0, b_q};

`ifdef FIB_OVF_EN
    // The wrap status follows the values through the pipeline of a/b: b's flag
    // is sticky over every carry that fed into b, and a inherits it when b
    // shifts into a. The result F(n) is a, so a's flag is what gets reported.
    // This keeps the extra look-ahead addition that produces F(n+1) from
    // flagging a result that did not itself wrap.
    logic           ovf_a_q, ovf_a_d;
    logic           ovf_b_q, ovf_b_d;
    logic           ovf_q, ovf_d;
`endif

    // Next-state and datapath update for the IDLE -> CALC -> DONE sequence.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        f_d     = f_q;
`ifdef FIB_OVF_EN
        ovf_a_d = ovf_a_q;
        ovf_b_d = ovf_b_q;
        ovf_d   = ovf_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = n;
                    a_d     = '0;
                    b_d     = F_W'(1);
`ifdef FIB_OVF_EN
                    ovf_a_d = 1'b0;
                    ovf_b_d = 1'b0;
`endif
                    state_d = CALC;
                end
            end

            CALC: begin
                if (cnt_q != '0) begin
                    a_d     = b_q;
                    b_d     = sum_w[F_W-1:0];
                    cnt_d   = cnt_q - N_W'(1);
`ifdef FIB_OVF_EN
                    ovf_a_d = ovf_b_q;
                    ovf_b_d = ovf_b_q | sum_w[F_W];
`endif
                end else begin
                    f_d     = a_q;
`ifdef FIB_OVF_EN
                    ovf_d   = ovf_a_q;
`endif
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this edge.
        if (reset) begin
            // NOTE: the datapath is reset too, because a and b seed the
            // recurrence and F is visible on the port straight after reset.
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= F_W'(1);
            cnt_q   <= '0;
            f_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            f_q     <= f_d;
        end
    end

`ifdef FIB_OVF_EN
    // Overflow tracking registers, reset alongside the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_a_q <= 1'b0;
            ovf_b_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            ovf_a_q <= ovf_a_d;
            ovf_b_q <= ovf_b_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    // Status outputs are pure decodes of the registered state.
    assign busy = (state_q == CALC);
    assign done = (state_q == DONE);
    assign F    = f_q;

endmodule

// File: tb/tb_parcial_junto.sv
// -----------------------------------------------------------------------------
// tb_parcial_junto
// Scoreboard bench for parcial_junto. Stimulus pushes the expected result and
// the cycle in which done must be high; a monitor on the falling edge pops an
// entry on every done pulse and compares F (and ovf when FIB_OVF_EN is set).
// The monitor also flags any change of F outside completion or reset.
// -----------------------------------------------------------------------------
module tb_parcial_junto;

    localparam int N_W = 16;
    localparam int F_W = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [N_W-1:0] n_in;
    logic [F_W-1:0] F;
    logic           busy;
    logic           done;
    logic           ovf;

    parcial_junto #(.N_W(N_W), .F_W(F_W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .n     (n_in),
        .F     (F),
        .busy  (busy),
        .done  (done)
`ifdef FIB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

`ifndef FIB_OVF_EN
    assign ovf = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic [F_W-1:0] f;
        logic           ovf;
        int             cyc;
    } exp_t;

    exp_t sb[$];

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic rst_edge = 1'b1;
    logic mon_en   = 1'b0;
    logic [F_W-1:0] f_prev;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Edge counter and reset-at-edge record, used by stimulus and monitor.
    always @(posedge clk) begin
        cyc++;
        rst_edge = reset;
    end

    // Monitor: compare on every done pulse, and watch F for stray updates.
    always @(negedge clk) begin
        if (mon_en) begin
            if (done) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result_F", 64'(F), 64'(e.f));
                    check("done_cycle", 64'(cyc), 64'(e.cyc));
`ifdef FIB_OVF_EN
                    check("result_ovf", 64'(ovf), 64'(e.ovf));
`endif
                end
            end else if (!rst_edge) begin
                check("F_hold", 64'(F), 64'(f_prev));
            end
        end
        f_prev = F;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) tick();
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy || done || sb.size() != 0) && k < 200) begin
            tick();
            k++;
        end
        if (k == 200) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got busy=%0d pending=%0d expected idle", busy, sb.size());
            sb.delete();
        end
    endtask

    // Single-cycle start pulse; done expected at E0+n+1 with the given result.
    task automatic run_one(input logic [N_W-1:0] nv, input logic [F_W-1:0] fv, input logic ov);
        int   e0;
        exp_t e;
        wait_idle();
        n_in  = nv;
        start = 1'b1;
        e0    = cyc + 1;
        e.f = fv; e.ovf = ov; e.cyc = e0 + int'(nv) + 1;
        sb.push_back(e);
        tick();
        check("busy_after_start", 64'(busy), 64'd1);
        start = 1'b0;
    endtask

    task automatic push_exp(input logic [F_W-1:0] fv, input int c);
        exp_t e;
        e.f = fv; e.ovf = 1'b0; e.cyc = c;
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200000ns");
        $fatal(1);
    end

    initial begin
        int e0;
        reset = 1'b1;
        start = 1'b0;
        n_in  = '0;

        // Reset held for two edges.
        tick();
        tick();
        check("reset_F", 64'(F), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
`ifdef FIB_OVF_EN
        check("reset_ovf", 64'(ovf), 64'd0);
`endif

        // Release with start low: stays idle, F stays 0.
        reset  = 1'b0;
        mon_en = 1'b1;
        repeat (3) tick();
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_done", 64'(done), 64'd0);
        check("idle_F", 64'(F), 64'd0);

        // Smallest indices.
        run_one(16'd0, 32'd0, 1'b0);
        run_one(16'd1, 32'd1, 1'b0);
        run_one(16'd2, 32'd1, 1'b0);

        // Held start with n=8, then n changes to 15 during a computation.
        wait_idle();
        n_in  = 16'd8;
        start = 1'b1;
        e0    = cyc + 1;
        push_exp(32'd21,  e0 + 9);
        push_exp(32'd21,  e0 + 20);
        push_exp(32'd21,  e0 + 31);
        push_exp(32'd610, e0 + 49);
        wait_cyc(e0 + 24);
        check("busy_held_calc", 64'(busy), 64'd1);
        n_in = 16'd15;
        wait_cyc(e0 + 33);
        start = 1'b0;

        // Largest index that fits, then the first wrapped one.
        run_one(16'd47, 32'd2971215073, 1'b0);
        run_one(16'd48, 32'd512559680, 1'b1);

        // Reset five cycles into an n=15 computation.
        wait_idle();
        n_in  = 16'd15;
        start = 1'b1;
        e0    = cyc + 1;
        tick();
        start = 1'b0;
        wait_cyc(e0 + 5);
        check("busy_before_reset", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        check("midreset_F", 64'(F), 64'd0);
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_done", 64'(done), 64'd0);
`ifdef FIB_OVF_EN
        check("midreset_ovf", 64'(ovf), 64'd0);
`endif
        reset = 1'b0;
        tick();
        check("post_reset_idle", 64'(busy), 64'd0);
        run_one(16'd15, 32'd610, 1'b0);

        wait_idle();
        repeat (3) tick();
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
